// File: rtl/phase_error_monitor.sv
// Windowed phase-error statistics (mean/min/max) for one selected channel,
// plus a lock flag driven by consecutive windows whose mean is near zero.
module phase_error_monitor #(
    parameter int WIDTH        = 8,
    parameter int CHANNELS     = 4,
    parameter int LOG2_WIN     = 4,
    parameter int LOCK_THRESH  = 2,
    parameter int LOCK_WINDOWS = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          enable_i,
    input  logic [$clog2(CHANNELS)-1:0]   ch_sel_i,
    input  logic [CHANNELS*WIDTH-1:0]     err_i,
    input  logic                          err_valid_i,
    output logic [WIDTH-1:0]              mean_o,
    output logic [WIDTH-1:0]              min_o,
    output logic [WIDTH-1:0]              max_o,
    output logic [$clog2(CHANNELS)-1:0]   ch_o,
    output logic                          result_valid_o,
    output logic                          locked_o
);
    localparam int CH_W  = $clog2(CHANNELS);
    localparam int ACC_W = WIDTH + LOG2_WIN;
    localparam int LC_W  = $clog2(LOCK_WINDOWS + 1);

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;
    state_t state_q, state_d;

    logic signed [WIDTH-1:0] err_arr [CHANNELS];
    logic [CH_W-1:0]         ch_req, ch_cur, ch_lat_q, ch_lat_d;
    logic [LOG2_WIN-1:0]     cnt_q, cnt_d;
    logic                    accept, first_smp, close;
    logic signed [WIDTH-1:0] sample;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [WIDTH-1:0] min_q, min_d, max_q, max_d;

    logic                    snap_valid_q, snap_valid_d;
    logic signed [ACC_W-1:0] snap_sum_q, snap_sum_d;
    logic signed [WIDTH-1:0] snap_min_q, snap_min_d, snap_max_q, snap_max_d;
    logic [CH_W-1:0]         snap_ch_q, snap_ch_d;

    logic signed [WIDTH-1:0] mean_w;
    logic [WIDTH:0]          mean_ext, mean_abs;
    logic                    good_win;
    logic [LC_W-1:0]         lock_cnt_q, lock_cnt_d;
    logic [WIDTH-1:0]        mean_q, mean_d, min_out_q, min_out_d, max_out_q, max_out_d;
    logic [CH_W-1:0]         ch_out_q, ch_out_d;
    logic                    result_valid_q, result_valid_d, locked_q, locked_d;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign err_arr[gi] = err_i[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Out-of-range channel requests fall back to channel 0.
    assign ch_req     = ({1'b0, ch_sel_i} >= (CH_W+1)'(CHANNELS)) ? '0 : ch_sel_i;
    assign accept     = (state_q == ACCUM) && enable_i && err_valid_i;
    assign first_smp  = (cnt_q == '0);
    assign ch_cur     = first_smp ? ch_req : ch_lat_q;
    assign sample     = err_arr[ch_cur];
    assign sample_ext = {{LOG2_WIN{sample[WIDTH-1]}}, sample};
    assign close      = accept && (cnt_q == {LOG2_WIN{1'b1}});

    assign mean_w   = WIDTH'(snap_sum_q >>> LOG2_WIN);
    assign mean_ext = {mean_w[WIDTH-1], mean_w};
    assign mean_abs = mean_w[WIDTH-1] ? (-mean_ext) : mean_ext;
    assign good_win = (mean_abs <= (WIDTH+1)'(LOCK_THRESH));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (enable_i)  state_d = ACCUM;
            ACCUM: if (!enable_i) state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        min_d        = min_q;
        max_d        = max_q;
        ch_lat_d     = ch_lat_q;
        snap_valid_d = close;
        snap_sum_d   = snap_sum_q;
        snap_min_d   = snap_min_q;
        snap_max_d   = snap_max_q;
        snap_ch_d    = snap_ch_q;

        if (state_d == IDLE) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
            if (first_smp) begin
                acc_d    = sample_ext;
                min_d    = sample;
                max_d    = sample;
                ch_lat_d = ch_req;
            end else begin
                acc_d = acc_q + sample_ext;
                if (sample < min_q) min_d = sample;
                if (sample > max_q) max_d = sample;
            end
        end

        if (close) begin
            snap_sum_d = acc_d;
            snap_min_d = min_d;
            snap_max_d = max_d;
            snap_ch_d  = ch_cur;
        end
    end

    always_comb begin
        mean_d         = mean_q;
        min_out_d      = min_out_q;
        max_out_d      = max_out_q;
        ch_out_d       = ch_out_q;
        result_valid_d = snap_valid_q;
        lock_cnt_d     = lock_cnt_q;

        if (snap_valid_q) begin
            mean_d    = mean_w;
            min_out_d = snap_min_q;
            max_out_d = snap_max_q;
            ch_out_d  = snap_ch_q;
            if (good_win) begin
                if (lock_cnt_q != LC_W'(LOCK_WINDOWS)) lock_cnt_d = lock_cnt_q + 1'b1;
            end else begin
                lock_cnt_d = '0;
            end
        end
        // Dropping to idle wins over any lock update from a pending result.
        if (state_d == IDLE) lock_cnt_d = '0;
        locked_d = (lock_cnt_d == LC_W'(LOCK_WINDOWS));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            acc_q          <= '0;
            min_q          <= '0;
            max_q          <= '0;
            ch_lat_q       <= '0;
            snap_valid_q   <= 1'b0;
            snap_sum_q     <= '0;
            snap_min_q     <= '0;
            snap_max_q     <= '0;
            snap_ch_q      <= '0;
            lock_cnt_q     <= '0;
            mean_q         <= '0;
            min_out_q      <= '0;
            max_out_q      <= '0;
            ch_out_q       <= '0;
            result_valid_q <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            min_q          <= min_d;
            max_q          <= max_d;
            ch_lat_q       <= ch_lat_d;
            snap_valid_q   <= snap_valid_d;
            snap_sum_q     <= snap_sum_d;
            snap_min_q     <= snap_min_d;
            snap_max_q     <= snap_max_d;
            snap_ch_q      <= snap_ch_d;
            lock_cnt_q     <= lock_cnt_d;
            mean_q         <= mean_d;
            min_out_q      <= min_out_d;
            max_out_q      <= max_out_d;
            ch_out_q       <= ch_out_d;
            result_valid_q <= result_valid_d;
            locked_q       <= locked_d;
        end
    end

    assign mean_o         = mean_q;
    assign min_o          = min_out_q;
    assign max_o          = max_out_q;
    assign ch_o           = ch_out_q;
    assign result_valid_o = result_valid_q;
    assign locked_o       = locked_q;

endmodule

// File: tb/tb_phase_error_monitor.sv
// Directed bench for phase_error_monitor with default parameters (16-sample windows).
module tb_phase_error_monitor;
    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        enable_i = 1'b0;
    logic [1:0]  ch_sel_i = 2'd0;
    logic [31:0] err_i = 32'd0;
    logic        err_valid_i = 1'b0;
    logic [7:0]  mean_o, min_o, max_o;
    logic [1:0]  ch_o;
    logic        result_valid_o, locked_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic signed [7:0] mean;
        logic signed [7:0] mn;
        logic signed [7:0] mx;
        logic [1:0]        ch;
        logic              lk;
        int                cyc;
    } res_t;
    res_t resq[$];

    phase_error_monitor dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .enable_i       (enable_i),
        .ch_sel_i       (ch_sel_i),
        .err_i          (err_i),
        .err_valid_i    (err_valid_i),
        .mean_o         (mean_o),
        .min_o          (min_o),
        .max_o          (max_o),
        .ch_o           (ch_o),
        .result_valid_o (result_valid_o),
        .locked_o       (locked_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (rst_n_i === 1'b1 && result_valid_o === 1'b1)
            resq.push_back('{$signed(mean_o), $signed(min_o), $signed(max_o), ch_o, locked_o, cyc});
    end

    function automatic logic [31:0] pack(input int ch, input logic [7:0] v);
        logic [31:0] w;
        w = 32'h55555555;
        w[ch*8 +: 8] = v;
        return w;
    endfunction

    task automatic drive(input bit en, input bit vld, input logic [1:0] sel, input logic [31:0] err);
        enable_i    = en;
        err_valid_i = vld;
        ch_sel_i    = sel;
        err_i       = err;
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_q(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (resq.size() >= n) break;
            @(negedge clk_i);
            #1;
        end
        if (resq.size() >= n) ok = 1'b1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        total++;
        if ({mean_o, min_o, max_o, ch_o, result_valid_o, locked_o} !== 28'd0) begin
            bad++;
            $display("FAIL reset_state: got %h want 0", {mean_o, min_o, max_o, ch_o, result_valid_o, locked_o});
        end
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_const();
        res_t r;
        bit ok;
        int e [3][5];
        int c [3];
        e = '{'{1, 1, 1, 0, 0}, '{1, 1, 1, 0, 0}, '{1, 1, 1, 0, 1}};
        resq.delete();
        drive(1, 1, 2'd0, pack(0, 8'd100));   // entry cycle: must be ignored
        for (int i = 0; i < 48; i++) drive(1, 1, 2'd0, pack(0, 8'd1));
        drive(1, 0, 2'd0, 32'd0);
        wait_q(3, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL const_count: got %0d results want 3", resq.size()); end
        for (int i = 0; i < 3; i++) begin
            c[i] = 0;
            if (resq.size() == 0) continue;
            r = resq.pop_front();
            c[i] = r.cyc;
            total++;
            if ({r.mean, r.mn, r.mx, r.ch, r.lk} !== {8'(e[i][0]), 8'(e[i][1]), 8'(e[i][2]), 2'(e[i][3]), 1'(e[i][4])}) begin
                bad++;
                $display("FAIL const_res%0d: got mean=%0d min=%0d max=%0d ch=%0d locked=%0b want mean=%0d min=%0d max=%0d ch=%0d locked=%0d",
                         i, r.mean, r.mn, r.mx, r.ch, r.lk, e[i][0], e[i][1], e[i][2], e[i][3], e[i][4]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            total++;
            if (c[i] - c[i-1] != 16) begin
                bad++;
                $display("FAIL const_period%0d: got %0d cycles want 16", i, c[i] - c[i-1]);
            end
        end
    endtask

    task automatic test_ramp();
        res_t r;
        int e [3][5];
        e = '{'{-1, -8, 7, 2, 1}, '{5, 5, 5, 2, 0}, '{1, 1, 1, 2, 0}};
        resq.delete();
        for (int i = 0; i < 16; i++) drive(1, 1, 2'd2, pack(2, 8'(i - 8)));
        for (int i = 0; i < 16; i++) drive(1, 1, 2'd2, pack(2, 8'd5));
        for (int i = 0; i < 16; i++) drive(1, 1, 2'd2, pack(2, 8'd1));
        err_valid_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (result_valid_o !== 1'b0) begin bad++; $display("FAIL ramp_latency_early: got %b want 0", result_valid_o); end
        @(negedge clk_i);
        total++;
        if (result_valid_o !== 1'b1) begin bad++; $display("FAIL ramp_latency: got %b want 1", result_valid_o); end
        @(negedge clk_i);
        total++;
        if (result_valid_o !== 1'b0) begin bad++; $display("FAIL ramp_pulse_width: got %b want 0", result_valid_o); end
        total++;
        if (resq.size() != 3) begin bad++; $display("FAIL ramp_count: got %0d results want 3", resq.size()); end
        for (int i = 0; i < 3; i++) begin
            if (resq.size() == 0) continue;
            r = resq.pop_front();
            total++;
            if ({r.mean, r.mn, r.mx, r.ch, r.lk} !== {8'(e[i][0]), 8'(e[i][1]), 8'(e[i][2]), 2'(e[i][3]), 1'(e[i][4])}) begin
                bad++;
                $display("FAIL ramp_res%0d: got mean=%0d min=%0d max=%0d ch=%0d locked=%0b want mean=%0d min=%0d max=%0d ch=%0d locked=%0d",
                         i, r.mean, r.mn, r.mx, r.ch, r.lk, e[i][0], e[i][1], e[i][2], e[i][3], e[i][4]);
            end
        end
    endtask

    task automatic test_most_negative();
        res_t r;
        bit ok;
        int e [3][5];
        e = '{'{0, 0, 0, 1, 0}, '{0, 0, 0, 1, 1}, '{-128, -128, -128, 1, 0}};
        resq.delete();
        for (int i = 0; i < 32; i++) drive(1, 1, 2'd1, pack(1, 8'd0));
        for (int i = 0; i < 16; i++) drive(1, 1, 2'd1, pack(1, 8'h80));
        drive(1, 0, 2'd1, 32'd0);
        wait_q(3, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL neg_count: got %0d results want 3", resq.size()); end
        for (int i = 0; i < 3; i++) begin
            if (resq.size() == 0) continue;
            r = resq.pop_front();
            total++;
            if ({r.mean, r.mn, r.mx, r.ch, r.lk} !== {8'(e[i][0]), 8'(e[i][1]), 8'(e[i][2]), 2'(e[i][3]), 1'(e[i][4])}) begin
                bad++;
                $display("FAIL neg_res%0d: got mean=%0d min=%0d max=%0d ch=%0d locked=%0b want mean=%0d min=%0d max=%0d ch=%0d locked=%0d",
                         i, r.mean, r.mn, r.mx, r.ch, r.lk, e[i][0], e[i][1], e[i][2], e[i][3], e[i][4]);
            end
        end
    endtask

    task automatic test_ch_switch();
        res_t r;
        bit ok;
        int e [5][5];
        int c [5];
        logic [31:0] dual;
        dual = {8'hFD, 8'h22, 8'h11, 8'h03};
        e = '{'{3, 3, 3, 0, 0}, '{-3, -3, -3, 3, 0}, '{7, 0, 15, 0, 0}, '{7, 0, 15, 0, 0}, '{7, 0, 15, 0, 0}};
        resq.delete();
        for (int i = 0; i < 16; i++) drive(1, 1, (i < 5) ? 2'd0 : 2'd3, dual);
        for (int i = 0; i < 16; i++) drive(1, 1, 2'd3, dual);
        for (int i = 0; i < 16; i++) drive(1, 1, 2'd0, pack(0, 8'(i)));
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 16; i++) begin
                drive(1, 1, 2'd0, pack(0, 8'(i)));
                drive(1, 0, 2'd0, pack(0, 8'd99));
            end
        end
        wait_q(5, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL chsel_count: got %0d results want 5", resq.size()); end
        for (int i = 0; i < 5; i++) begin
            c[i] = 0;
            if (resq.size() == 0) continue;
            r = resq.pop_front();
            c[i] = r.cyc;
            total++;
            if ({r.mean, r.mn, r.mx, r.ch, r.lk} !== {8'(e[i][0]), 8'(e[i][1]), 8'(e[i][2]), 2'(e[i][3]), 1'(e[i][4])}) begin
                bad++;
                $display("FAIL chsel_res%0d: got mean=%0d min=%0d max=%0d ch=%0d locked=%0b want mean=%0d min=%0d max=%0d ch=%0d locked=%0d",
                         i, r.mean, r.mn, r.mx, r.ch, r.lk, e[i][0], e[i][1], e[i][2], e[i][3], e[i][4]);
            end
        end
        total++;
        if (c[2] - c[1] != 16) begin bad++; $display("FAIL chsel_period_full: got %0d want 16", c[2] - c[1]); end
        total++;
        if (c[4] - c[3] != 32) begin bad++; $display("FAIL chsel_period_half: got %0d want 32", c[4] - c[3]); end
    endtask

    task automatic test_abort();
        res_t r;
        bit ok;
        int e [7][5];
        e = '{'{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 1},
              '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 1}, '{0, 0, 0, 0, 0}};
        resq.delete();
        for (int i = 0; i < 48; i++) drive(1, 1, 2'd0, pack(0, 8'd0));
        for (int i = 0; i < 9; i++) drive(1, 1, 2'd0, pack(0, 8'd50));
        total++;
        if (locked_o !== 1'b1) begin bad++; $display("FAIL abort_pre_locked: got %b want 1", locked_o); end
        drive(0, 1, 2'd0, pack(0, 8'd50));
        total++;
        if (locked_o !== 1'b0) begin bad++; $display("FAIL abort_locked: got %b want 0", locked_o); end
        drive(1, 1, 2'd0, pack(0, 8'd50));   // entry cycle: must be ignored
        for (int i = 0; i < 64; i++) drive(1, 1, 2'd0, pack(0, 8'd0));
        drive(0, 0, 2'd0, 32'd0);             // abort while the last snapshot is pending
        wait_q(7, ok);
        total++;
        if (!ok || resq.size() != 7) begin bad++; $display("FAIL abort_count: got %0d results want 7", resq.size()); end
        for (int i = 0; i < 7; i++) begin
            if (resq.size() == 0) continue;
            r = resq.pop_front();
            total++;
            if ({r.mean, r.mn, r.mx, r.ch, r.lk} !== {8'(e[i][0]), 8'(e[i][1]), 8'(e[i][2]), 2'(e[i][3]), 1'(e[i][4])}) begin
                bad++;
                $display("FAIL abort_res%0d: got mean=%0d min=%0d max=%0d ch=%0d locked=%0b want mean=%0d min=%0d max=%0d ch=%0d locked=%0d",
                         i, r.mean, r.mn, r.mx, r.ch, r.lk, e[i][0], e[i][1], e[i][2], e[i][3], e[i][4]);
            end
        end
    endtask

    task automatic test_async_reset();
        res_t r;
        bit ok;
        resq.delete();
        drive(1, 1, 2'd2, pack(2, 8'd1));
        for (int i = 0; i < 48; i++) drive(1, 1, 2'd2, pack(2, 8'd1));
        for (int i = 0; i < 7; i++) drive(1, 1, 2'(i), (i % 2 == 1) ? pack(2, 8'd3) : pack(1, 8'hF0));
        total++;
        if ({mean_o, ch_o, locked_o} !== {8'd1, 2'd2, 1'b1}) begin
            bad++;
            $display("FAIL areset_pre: got mean=%0d ch=%0d locked=%b want mean=1 ch=2 locked=1", mean_o, ch_o, locked_o);
        end
        #2 rst_n_i = 1'b0;
        #1;
        total++;
        if ({mean_o, min_o, max_o, ch_o, result_valid_o, locked_o} !== 28'd0) begin
            bad++;
            $display("FAIL areset_async: got %h want 0", {mean_o, min_o, max_o, ch_o, result_valid_o, locked_o});
        end
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        resq.delete();
        for (int i = 0; i < 16; i++) drive(1, 1, 2'd2, pack(2, 8'd1));   // first is the entry cycle
        for (int i = 0; i < 6; i++) drive(1, 0, 2'd2, 32'd0);
        total++;
        if (resq.size() != 0) begin bad++; $display("FAIL areset_early: got %0d results want 0", resq.size()); end
        drive(1, 1, 2'd2, pack(2, 8'd1));
        drive(1, 0, 2'd2, 32'd0);
        wait_q(1, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL areset_first: got no result want one");
        end else begin
            r = resq.pop_front();
            if ({r.mean, r.mn, r.mx, r.ch, r.lk} !== {8'sd1, 8'sd1, 8'sd1, 2'd2, 1'b0}) begin
                bad++;
                $display("FAIL areset_first: got mean=%0d min=%0d max=%0d ch=%0d locked=%0b want mean=1 min=1 max=1 ch=2 locked=0",
                         r.mean, r.mn, r.mx, r.ch, r.lk);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_const();
        test_ramp();
        test_most_negative();
        test_ch_switch();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_error_monitor.md
# phase_error_monitor

Parametrised phase-error statistics and lock-detect block for the ADPLL test harness. It takes the signed phase-error words of up to CHANNELS loops or detectors and accumulates the selected channel over fixed windows of 2^LOG2_WIN valid samples. Per window it reports mean, minimum and maximum. A lock flag is driven from consecutive in-threshold window means. It sits between the ADPLL error outputs and the signed-to-hex / seven-segment display path, and replaces single-sample error display.

## Interface
Parameters:
- WIDTH, 8: width of each signed error word.
- CHANNELS, 4: number of error channels, at least 2.
- LOG2_WIN, 4: window length is 2^LOG2_WIN valid samples, range 1..8.
- LOCK_THRESH, 2: lock when |mean| <= LOCK_THRESH. Unsigned, less than 2^(WIDTH-1).
- LOCK_WINDOWS, 3: number of consecutive good windows needed to assert lock, at least 1.

Ports (clock and reset first):
- clk_i, in, 1: single clock. Every flop is on its rising edge.
- rst_n_i, in, 1: asynchronous, active-low reset.
- enable_i, in, 1: run. Low means idle and abort.
- ch_sel_i, in, $clog2(CHANNELS): requested channel.
- err_i, in, CHANNELS*WIDTH: packed signed errors. Channel c is at [c*WIDTH +: WIDTH].
- err_valid_i, in, 1: sample strobe, one sample per high cycle.
- mean_o, out, WIDTH: signed window mean.
- min_o, out, WIDTH: signed window minimum.
- max_o, out, WIDTH: signed window maximum.
- ch_o, out, $clog2(CHANNELS): channel the current results belong to.
- result_valid_o, out, 1: one-cycle pulse when new results are presented.
- locked_o, out, 1: lock indication.

## Operation
- Reset values: all outputs are 0, the FSM is in IDLE, and the accumulator, sample count and lock count are all 0.
- FSM has two states, IDLE and ACCUM.
- IDLE to ACCUM when enable_i=1. ACCUM to IDLE when enable_i=0.
- Entering IDLE:
  - The partial window is discarded.
  - The lock count is cleared and locked_o clears at the same edge.
  - mean_o, min_o, max_o and ch_o hold their values.
- Channel latch: ch_sel_i is sampled when the first sample of a window is accepted. Changes to ch_sel_i mid-window have no effect until the next window. A ch_sel_i value of CHANNELS or more selects channel 0.
- Sample acceptance: a sample is accepted only when the state is ACCUM and err_valid_i=1. The cycle that enters ACCUM accepts nothing.
- Accumulator:
  - Signed, WIDTH+LOG2_WIN bits, so it cannot overflow.
  - The first sample of a window loads the accumulator, min and max directly.
  - Later samples add to the accumulator and update running min and max, signed compare.
- Window close: when the sample count reaches 2^LOG2_WIN-1 and a sample is accepted:
  - The snapshot takes sum+sample, final min/max and the latched channel.
  - The count wraps to 0.
  - Windows run back-to-back with no lost samples. A sample accepted on the next cycle starts the new window.
- Mean: the snapshot sum arithmetic-shifted right by LOG2_WIN, so it floors toward negative infinity. The result always fits in WIDTH bits.
- Lock evaluation: |mean| is computed in WIDTH+1 bits, so the most negative value is handled without wrap.
  - Good window (|mean| <= LOCK_THRESH): the lock count increments, saturating at LOCK_WINDOWS.
  - Bad window: the lock count goes to 0.
  - locked_o = (lock count == LOCK_WINDOWS). It is updated together with the results.

## Timing
- Last sample of a window accepted at edge k: the snapshot registers at edge k.
- At edge k+1:
  - mean_o, min_o, max_o, ch_o and locked_o update.
  - result_valid_o is high for exactly the cycle after edge k+1.
  - Latency is 2 edges from the last sample to the results.
- Minimum window period is 2^LOG2_WIN cycles, so a result_valid_o pulse can follow the previous one every 2^LOG2_WIN cycles.
- enable_i falls while a snapshot is pending (between edges k and k+1): the pending result is still delivered at k+1. locked_o is then forced to 0 at k+1, because the abort takes priority over the lock update.
- rst_n_i asserted at any time: all state and outputs go to reset values immediately, with no clock needed.
- Release of rst_n_i is synchronised externally. After release, the block starts in IDLE.

## Test plan
- Reset check: assert rst_n_i mid-window with toggling inputs. All outputs must go to 0 asynchronously. After release, the first result appears only after 16 new samples.
- Constant err=+1 on ch0, defaults, continuous valid:
  - Every 16 cycles: mean=1, min=1, max=1, ch_o=0.
  - locked_o rises with the 3rd result_valid_o pulse.
- Ramp -8..+7 on ch2:
  - Expected: sum=-8, mean=-1 (floor of -0.5), min=-8, max=7.
  - A following window of all +5 gives mean=5, locked_o=0, and the lock count reset.
- All samples -128 on ch1:
  - Expected: mean=-128, min=max=-128.
  - |mean|=128 exceeds the threshold, so a previously set locked_o drops at the same edge as result_valid_o.
- ch_sel_i changed from 0 to 3 at sample 5 of a window:
  - The current window reports ch_o=0 with ch0 data.
  - The next window reports ch_o=3.
  - err_valid_i held low on alternate cycles halves the result rate with identical values.
- enable_i low for 1 cycle at sample 9:
  - The partial window is discarded and locked_o goes to 0.
  - The next result is produced from 16 fresh samples.
